// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer
// Wishbone pipelined master that rewrites the 8 row registers of the 8x8 RGB
// matrix with a rotating colour pattern, then idles for a programmable number
// of cycles and starts the next frame. One transaction is outstanding at a
// time; cyc is held across all 8 rows of a frame.
//
// Optional feature: define MATRIX_SEQ_TIMEOUT_EN to abandon a frame when the
// slave does not ack within ACK_TIMEOUT cycles (sets sticky o_err). Without
// the macro the master waits for ack indefinitely and o_err is constant 0.
//
// All outputs are registered: they are decoded from the next-state values so
// they line up with the state they describe.

module matrix_frame_sequencer #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 3,
  parameter int PERIOD_WIDTH  = 16,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic [PERIOD_WIDTH-1:0]  i_frame_period,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [3:0]               o_wb_sel,
  output logic [WB_DATA_WIDTH-1:0] o_wb_wdata,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_stall,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic [2:0]               o_phase,
  output logic                     o_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_ACK_WAIT = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT     = 3'd4
  } state_t;

  state_t                  state_r, state_nxt_s, resume_state_s;
  logic [2:0]              row_r, row_nxt_s;
  logic [2:0]              phase_r, phase_nxt_s;
  logic [PERIOD_WIDTH-1:0] period_r, period_nxt_s, resume_period_s;

`ifdef MATRIX_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
  logic             err_nxt_s;
`else
  localparam int unused_ack_timeout_c = ACK_TIMEOUT;
`endif

  // Row word: column c nibble (c=0 in the top nibble) is ((row+c+phase) mod 7)+1.
  function automatic logic [31:0] row_pattern(input logic [2:0] row, input logic [2:0] phase);
    logic [4:0] sum;
    logic [4:0] rem;
    row_pattern = 32'h0000_0000;
    for (int c = 0; c < 8; c++) begin
      sum = 5'(row) + 5'(c) + 5'(phase);
      rem = sum % 5'd7;
      row_pattern[31 - 4*c -: 4] = rem[3:0] + 4'd1;
    end
  endfunction

  // Where a finished (or abandoned) frame goes next. The idle counter holds
  // "remaining idle cycles minus one" so that the next strobe appears exactly
  // period+1 cycles after the frame ends; a zero period skips WAIT entirely.
  always_comb begin
    resume_period_s = '0;
    if (!i_enable) begin
      resume_state_s = ST_IDLE;
    end else if (i_frame_period == '0) begin
      resume_state_s = ST_ISSUE;
    end else begin
      resume_state_s  = ST_WAIT;
      resume_period_s = i_frame_period - PERIOD_WIDTH'(1);
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    row_nxt_s    = row_r;
    phase_nxt_s  = phase_r;
    period_nxt_s = period_r;
`ifdef MATRIX_SEQ_TIMEOUT_EN
    tmo_nxt_s    = '0;
    err_nxt_s    = o_err;
`endif
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          state_nxt_s = ST_ISSUE;
          row_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Outputs hold while stalled; the first unstalled strobe is accepted.
        if (!i_wb_stall) begin
          state_nxt_s = ST_ACK_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_ACK_WAIT: begin
        if (i_wb_ack) begin
          if (row_r == 3'd7) begin
            state_nxt_s = ST_DONE;
          end else begin
            row_nxt_s   = row_r + 3'd1;
            state_nxt_s = ST_ISSUE;
          end
        end
`ifdef MATRIX_SEQ_TIMEOUT_EN
        else if (tmo_r == TMO_W'(ACK_TIMEOUT - 1)) begin
          // Slave went silent: give up on this frame without advancing phase.
          err_nxt_s    = 1'b1;
          row_nxt_s    = 3'd0;
          state_nxt_s  = resume_state_s;
          period_nxt_s = resume_period_s;
        end else begin
          tmo_nxt_s = tmo_r + TMO_W'(1);
        end
`else
        else begin
          state_nxt_s = ST_ACK_WAIT;
        end
`endif
      end
      ST_DONE: begin
        phase_nxt_s  = (phase_r == 3'd6) ? 3'd0 : phase_r + 3'd1;
        row_nxt_s    = 3'd0;
        state_nxt_s  = resume_state_s;
        period_nxt_s = resume_period_s;
      end
      ST_WAIT: begin
        if (!i_enable) begin
          state_nxt_s = ST_IDLE;
        end else if (period_r == '0) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          period_nxt_s = period_r - PERIOD_WIDTH'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        row_nxt_s   = 3'd0;
      end
    endcase
  end

  // State, row, phase and idle-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      row_r    <= 3'd0;
      phase_r  <= 3'd0;
      period_r <= '0;
`ifdef MATRIX_SEQ_TIMEOUT_EN
      tmo_r    <= '0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      row_r    <= row_nxt_s;
      phase_r  <= phase_nxt_s;
      period_r <= period_nxt_s;
`ifdef MATRIX_SEQ_TIMEOUT_EN
      tmo_r    <= tmo_nxt_s;
`endif
    end
  end

  // Registered bus and status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_sel     <= 4'h0;
      o_wb_wdata   <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_phase      <= 3'd0;
      o_err        <= 1'b0;
    end else begin
      o_wb_cyc     <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_ACK_WAIT);
      o_wb_stb     <= (state_nxt_s == ST_ISSUE);
      o_wb_we      <= (state_nxt_s == ST_ISSUE);
      o_wb_addr    <= WB_ADDR_WIDTH'(row_nxt_s);
      o_wb_sel     <= (state_nxt_s == ST_ISSUE) ? 4'hf : 4'h0;
      o_wb_wdata   <= (state_nxt_s == ST_ISSUE) ?
                      WB_DATA_WIDTH'(row_pattern(row_nxt_s, phase_nxt_s)) : '0;
      o_busy       <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_ACK_WAIT) ||
                      (state_nxt_s == ST_DONE);
      o_frame_done <= (state_nxt_s == ST_DONE);
      o_phase      <= phase_nxt_s;
`ifdef MATRIX_SEQ_TIMEOUT_EN
      o_err        <= err_nxt_s;
`else
      o_err        <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Self-checking bench for matrix_frame_sequencer: directed frame sequence with
// randomized stalls and frame periods, checked against a pattern/timing model.

module tb_matrix_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic [15:0] i_frame_period;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_wdata;
  logic        i_wb_ack, i_wb_stall;
  logic        o_busy, o_frame_done, o_err;
  logic [2:0]  o_phase;

  int checks    = 0;
  int errors    = 0;
  int cyc_cnt   = 0;
  int acc_count = 0;
  int ph;
  int w;

  logic [31:0] ph0_tbl [8] = '{32'h12345671, 32'h23456712, 32'h34567123, 32'h45671234,
                               32'h56712345, 32'h67123456, 32'h71234567, 32'h12345671};

  matrix_frame_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (i_enable),
    .i_frame_period (i_frame_period),
    .o_wb_cyc       (o_wb_cyc),
    .o_wb_stb       (o_wb_stb),
    .o_wb_we        (o_wb_we),
    .o_wb_addr      (o_wb_addr),
    .o_wb_sel       (o_wb_sel),
    .o_wb_wdata     (o_wb_wdata),
    .i_wb_ack       (i_wb_ack),
    .i_wb_stall     (i_wb_stall),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_phase        (o_phase),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  // Count accepted transfers (strobe high, not stalled) at each clock edge.
  always @(posedge clk) begin
    if (o_wb_stb === 1'b1 && i_wb_stall === 1'b0) acc_count <= acc_count + 1;
  end

  // Reference row word: nibble for column c is ((row+c+phase) mod 7)+1, c=0 first.
  function automatic logic [31:0] exp_word(input int row, input int phase);
    logic [31:0] wd;
    wd = 32'h0;
    for (int c = 0; c < 8; c++) wd = {wd[27:0], 4'((row + c + phase) % 7 + 1)};
    return wd;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Wait (bounded) for a strobe; returns the number of clock edges waited.
  task automatic wait_stb(output int waited);
    waited = 0;
    while (o_wb_stb !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (o_wb_stb !== 1'b1) check("stb_timeout", 32'(o_wb_stb), 32'd1);
  endtask

  // Serve one full frame as a slave acking one cycle after acceptance.
  task automatic serve_frame(input int fph, input int exp_wait, input int stall_row,
                             input int stall_len, input int drop_row);
    int waited;
    int t0;
    int acc0;
    int a0;
    acc0 = acc_count;
    wait_stb(waited);
    if (exp_wait >= 0) check("start_wait", 32'(waited), 32'(exp_wait));
    t0 = cyc_cnt;
    check("phase_out", 32'(o_phase), 32'(fph));
    for (int r = 0; r < 8; r++) begin
      if (r > 0) check("stb_next_row", 32'(o_wb_stb), 32'd1);
      check("addr", 32'(o_wb_addr), 32'(r));
      check("wdata", o_wb_wdata, exp_word(r, fph));
      if (fph == 0) check("wdata_tbl", o_wb_wdata, ph0_tbl[r]);
      check("sel_we", {27'd0, o_wb_we, o_wb_sel}, 32'h1f);
      check("busy_issue", 32'(o_busy), 32'd1);
      if (r == drop_row) i_enable = 1'b0;
      if (r == stall_row) begin
        a0 = acc_count;
        i_wb_stall = 1'b1;
        i_wb_ack   = 1'b1;   // ack during ISSUE must be ignored
        for (int k = 0; k < stall_len; k++) begin
          tick();
          i_wb_ack = 1'b0;
          check("stall_stb", 32'(o_wb_stb), 32'd1);
          check("stall_addr", 32'(o_wb_addr), 32'(r));
          check("stall_wdata", o_wb_wdata, exp_word(r, fph));
        end
        i_wb_stall = 1'b0;
        tick();
        check("stall_one_xfer", 32'(acc_count - a0), 32'd1);
      end else begin
        tick();
      end
      check("ackwait_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'h2);
      i_wb_ack = 1'b1;
      tick();
      i_wb_ack = 1'b0;
    end
    check("frame_done", 32'(o_frame_done), 32'd1);
    check("done_cyc", 32'(o_wb_cyc), 32'd0);
    check("frame_len", 32'(cyc_cnt - t0),
          32'(16 + ((stall_row >= 0 && stall_row < 8) ? stall_len : 0)));
    check("frame_xfers", 32'(acc_count - acc0), 32'd8);
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b0; i_frame_period = 16'd0;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0;
    tick(); tick();
    check("rst_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr}, 32'h0);
    check("rst_wdata", o_wb_wdata, 32'h0);
    check("rst_status", {o_busy, o_frame_done, o_phase, o_err}, 32'h0);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_stb", {o_wb_cyc, o_wb_stb, o_busy}, 32'h0);

    // First frame from IDLE, then 6 more: phase walks 1..6,0; row 3 stalled once.
    ph = 0;
    i_enable = 1'b1;
    serve_frame(ph, 1, -1, 0, -1);
    ph = (ph + 1) % 7;
    for (int f = 1; f < 7; f++) begin
      serve_frame(ph, 1, (f == 2) ? 3 : -1, 5, -1);
      ph = (ph + 1) % 7;
    end
    // Frame 8 is back at phase 0 and must match the phase-0 table again.
    serve_frame(ph, 1, -1, 0, -1);
    ph = (ph + 1) % 7;

    // Period 10: next strobe 11 cycles after the done cycle.
    i_frame_period = 16'd10;
    serve_frame(ph, 11, -1, 0, -1);
    ph = (ph + 1) % 7;

    // Period 3 then drop enable during WAIT: no further strobe.
    i_frame_period = 16'd3;
    tick();
    check("done_pulse_low", 32'(o_frame_done), 32'd0);
    check("wait_not_busy", {o_busy, o_wb_cyc}, 32'h0);
    check("phase_after_done", 32'(o_phase), 32'(ph));
    tick();
    i_enable = 1'b0;
    tick();
    check("idle_after_disable", {o_busy, o_wb_cyc}, 32'h0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (o_wb_stb !== 1'b0) check("no_stb_disabled", 32'(o_wb_stb), 32'd0);
    end

    // Randomized periods and stalls.
    i_enable = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int p;
      int sr;
      int sl;
      p  = int'($urandom_range(0, 12));
      sr = int'($urandom_range(0, 9));
      sl = int'($urandom_range(1, 4));
      i_frame_period = 16'(p);
      serve_frame(ph, (f == 0) ? 1 : p + 1, (sr < 8) ? sr : -1, sl, -1);
      ph = (ph + 1) % 7;
    end

    // Enable dropped during row 2: frame still completes, then IDLE.
    i_frame_period = 16'd0;
    serve_frame(ph, 1, -1, 0, 2);
    ph = (ph + 1) % 7;
    tick();
    check("idle_after_drop", {o_busy, o_wb_cyc}, 32'h0);
    check("phase_after_drop", 32'(o_phase), 32'(ph));
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_wb_stb !== 1'b0) check("no_stb_after_drop", 32'(o_wb_stb), 32'd0);
    end

    // Async reset while waiting for ack: cyc drops at once, restart at phase 0.
    i_enable = 1'b1;
    wait_stb(w);
    check("restart_wait", 32'(w), 32'd1);
    check("restart_phase", 32'(o_phase), 32'(ph));
    tick();
    check("pre_rst_cyc", {o_wb_cyc, o_wb_stb}, 32'h2);
    reset = 1'b1;
    #1;
    check("async_rst_bus", {o_wb_cyc, o_wb_stb, o_busy}, 32'h0);
    check("async_rst_phase", 32'(o_phase), 32'd0);
    tick();
    reset = 1'b0;
    ph = 0;
    serve_frame(ph, 1, -1, 0, -1);
    check("no_err", 32'(o_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
